// File: rtl/muldiv_sched.sv
// Shared radix-2 multiply/divide engine for both issue slots.
// Ports: clk/resetn, flush_i, slot requests s{0,1}_*, stall_o, busy_o, HI/LO write.
module muldiv_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             s0_valid_i,
  input  logic [1:0]       s0_op_i,
  input  logic [WIDTH-1:0] s0_rs_i,
  input  logic [WIDTH-1:0] s0_rt_i,
  input  logic             s1_valid_i,
  input  logic [1:0]       s1_op_i,
  input  logic [WIDTH-1:0] s1_rs_i,
  input  logic [WIDTH-1:0] s1_rt_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             pend1_q;
  logic [1:0]       p_op_q;
  logic [WIDTH-1:0] p_rs_q;
  logic [WIDTH-1:0] p_rt_q;
  logic [CW-1:0]    cnt_q;

  // op_q[1] = divide, op_q[0] = unsigned
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] rs_q;
  logic             rt_s_q;
  logic             rt_zero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic launch, use_pend, latch_pend, iterate;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (s0_valid_i || s1_valid_i) state_d = CALC;
      CALC: if (cnt_q == CW'(WIDTH-1))    state_d = FIN;
      FIN:  state_d = pend1_q ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // ---------------- outputs / control ----------------
  always_comb begin
    stall_o    = 1'b0;
    hilo_we_o  = 1'b0;
    launch     = 1'b0;
    use_pend   = 1'b0;
    latch_pend = 1'b0;
    iterate    = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o    = (s0_valid_i | s1_valid_i) & ~flush_i;
        launch     = stall_o;
        latch_pend = s0_valid_i & s1_valid_i & ~flush_i;
      end
      CALC: begin
        stall_o = ~flush_i;
        iterate = ~flush_i;
      end
      FIN: begin
        hilo_we_o = ~flush_i;
        stall_o   = pend1_q & ~flush_i;
        launch    = stall_o;
        use_pend  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // ---------------- launch operand selection ----------------
  logic [1:0]       l_op;
  logic [WIDTH-1:0] l_rs, l_rt, l_amag, l_bmag;
  logic             l_sgn;

  always_comb begin
    if (use_pend) begin
      l_op = p_op_q; l_rs = p_rs_q; l_rt = p_rt_q;
    end else if (s0_valid_i) begin
      l_op = s0_op_i; l_rs = s0_rs_i; l_rt = s0_rt_i;
    end else begin
      l_op = s1_op_i; l_rs = s1_rs_i; l_rt = s1_rt_i;
    end
    l_sgn  = ~l_op[0];
    l_amag = (l_sgn && l_rs[WIDTH-1]) ? -l_rs : l_rs;
    l_bmag = (l_sgn && l_rt[WIDTH-1]) ? -l_rt : l_rt;
  end

  // ---------------- one iteration ----------------
  // mult: {acc_hi,acc_lo} shifts right, m added when lo[0] set.
  // div : {acc_hi,acc_lo} shifts left, quotient bits enter acc_lo.
  logic [WIDTH:0]   sum, r_sh;
  logic [WIDTH-1:0] diff, it_hi, it_lo;
  logic             ge;

  always_comb begin
    sum   = {1'b0, acc_hi_q} + ({(WIDTH+1){acc_lo_q[0]}} & {1'b0, m_q});
    r_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge    = (r_sh >= {1'b0, m_q});
    diff  = r_sh[WIDTH-1:0] - m_q;
    if (op_q[1]) begin
      it_hi = ge ? diff : r_sh[WIDTH-1:0];
      it_lo = {acc_lo_q[WIDTH-2:0], ge};
    end else begin
      it_hi = sum[WIDTH:1];
      it_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               sgn, rs_s;

  always_comb begin
    sgn  = ~op_q[0];
    rs_s = rs_q[WIDTH-1];
    prod = {acc_hi_q, acc_lo_q};
    if (sgn && (rs_s ^ rt_s_q)) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      res_lo = (sgn && (rs_s ^ rt_s_q)) ? -acc_lo_q : acc_lo_q;
      res_hi = (sgn && rs_s) ? -acc_hi_q : acc_hi_q;
      if (rt_zero_q) begin
        res_lo = '1;
        res_hi = rs_q;
      end
    end
  end

  assign hi_o = hilo_we_o ? res_hi : hi_q;
  assign lo_o = hilo_we_o ? res_lo : lo_q;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend1_q   <= 1'b0;
      p_op_q    <= '0;
      p_rs_q    <= '0;
      p_rt_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      m_q       <= '0;
      rs_q      <= '0;
      rt_s_q    <= 1'b0;
      rt_zero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (flush_i) begin
      pend1_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (launch) begin
        op_q      <= l_op;
        acc_hi_q  <= '0;
        acc_lo_q  <= l_op[1] ? l_amag : l_bmag;
        m_q       <= l_op[1] ? l_bmag : l_amag;
        rs_q      <= l_rs;
        rt_s_q    <= l_rt[WIDTH-1];
        rt_zero_q <= (l_rt == '0);
        cnt_q     <= '0;
      end else if (iterate) begin
        acc_hi_q <= it_hi;
        acc_lo_q <= it_lo;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (latch_pend) begin
        pend1_q <= 1'b1;
        p_op_q  <= s1_op_i;
        p_rs_q  <= s1_rs_i;
        p_rt_q  <= s1_rt_i;
      end else if (launch && use_pend) begin
        pend1_q <= 1'b0;
      end
      if (hilo_we_o) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched.
// Cycle 0 = accept cycle; outputs sampled 1 time unit after each rising edge.
module tb_muldiv_sched;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush_i;
  logic         s0_valid_i, s1_valid_i;
  logic [1:0]   s0_op_i, s1_op_i;
  logic [W-1:0] s0_rs_i, s0_rt_i, s1_rs_i, s1_rt_i;
  logic         stall_o, busy_o, hilo_we_o;
  logic [W-1:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int early_we = 0;
  int early_idle = 0;

  muldiv_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush_i    (flush_i),
    .s0_valid_i (s0_valid_i),
    .s0_op_i    (s0_op_i),
    .s0_rs_i    (s0_rs_i),
    .s0_rt_i    (s0_rt_i),
    .s1_valid_i (s1_valid_i),
    .s1_op_i    (s1_op_i),
    .s1_rs_i    (s1_rs_i),
    .s1_rt_i    (s1_rt_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .hilo_we_o  (hilo_we_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic advance(input int n);
    while (cyc < n) begin
      tick();
      if (cyc < n) begin
        if (hilo_we_o) early_we++;
        if (!stall_o)  early_idle++;
      end
    end
  endtask

  task automatic launch(input logic v0, input logic [1:0] op0,
                        input logic [W-1:0] rs0, input logic [W-1:0] rt0,
                        input logic v1, input logic [1:0] op1,
                        input logic [W-1:0] rs1, input logic [W-1:0] rt1);
    s0_valid_i = v0; s0_op_i = op0; s0_rs_i = rs0; s0_rt_i = rt0;
    s1_valid_i = v1; s1_op_i = op1; s1_rs_i = rs1; s1_rt_i = rt1;
    #1;
    cyc = 0;
    early_we = 0;
    early_idle = 0;
    chk("accept_stall", {63'd0, stall_o}, 64'd1);
    tick();
    s0_valid_i = 1'b0;
    s1_valid_i = 1'b0;
  endtask

  task automatic strobe(input string tag, input logic [W-1:0] hi,
                        input logic [W-1:0] lo);
    chk({tag, "_we"}, {63'd0, hilo_we_o}, 64'd1);
    chk({tag, "_hilo"}, {hi_o, lo_o}, {hi, lo});
  endtask

  initial begin
    resetn = 1'b0; flush_i = 1'b0;
    s0_valid_i = 1'b0; s1_valid_i = 1'b0;
    s0_op_i = '0; s1_op_i = '0;
    s0_rs_i = '0; s0_rt_i = '0; s1_rs_i = '0; s1_rt_i = '0;
    #2;
    chk("rst_out", {busy_o, stall_o, hilo_we_o, hi_o, lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // multu max*max
    launch(1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 2'b00, 0, 0);
    chk("calc_busy", {63'd0, busy_o}, 64'd1);
    advance(33);
    chk("multu_early", 64'(early_we + early_idle), 64'd0);
    strobe("multu", 32'hFFFFFFFE, 32'h00000001);
    chk("multu_stall", {63'd0, stall_o}, 64'd0);
    tick();
    chk("multu_after", {hilo_we_o, busy_o, hi_o, lo_o},
        {2'b00, 32'hFFFFFFFE, 32'h00000001});

    // dual: s0 mult -3*5, s1 divu 100/7
    tick();
    launch(1, 2'b00, 32'hFFFFFFFD, 32'd5, 1, 2'b11, 32'd100, 32'd7);
    advance(33);
    strobe("dual0", 32'hFFFFFFFF, 32'hFFFFFFF1);
    chk("dual0_stall", {63'd0, stall_o}, 64'd1);
    advance(66);
    chk("dual_early", 64'(early_we + early_idle), 64'd0);
    strobe("dual1", 32'd2, 32'd14);
    chk("dual1_stall", {63'd0, stall_o}, 64'd0);
    tick();

    // div -7/2
    launch(1, 2'b10, 32'hFFFFFFF9, 32'd2, 0, 2'b00, 0, 0);
    advance(33);
    strobe("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    tick();

    // divu 5/0
    launch(1, 2'b11, 32'd5, 32'd0, 0, 2'b00, 0, 0);
    advance(33);
    strobe("divu_z", 32'd5, 32'hFFFFFFFF);
    tick();

    // div min/-1
    launch(1, 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 2'b00, 0, 0);
    advance(33);
    chk("ovf_early", 64'(early_we), 64'd0);
    strobe("div_ovf", 32'd0, 32'h80000000);
    tick();

    // div -7/0: raw rs in HI
    launch(1, 2'b10, 32'hFFFFFFF9, 32'd0, 0, 2'b00, 0, 0);
    advance(33);
    strobe("div_z", 32'hFFFFFFF9, 32'hFFFFFFFF);
    tick();

    // s1-only request
    launch(0, 2'b00, 0, 0, 1, 2'b11, 32'd100, 32'd7);
    advance(33);
    strobe("s1only", 32'd2, 32'd14);
    tick();

    // flush at counter=10 with pending op
    launch(1, 2'b01, 32'd3, 32'd4, 1, 2'b01, 32'd5, 32'd6);
    advance(11);
    flush_i = 1'b1;
    #1;
    chk("flush_stall", {hilo_we_o, stall_o}, 2'b00);
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_idle", {busy_o, stall_o}, 2'b00);
    early_we = 0;
    advance(90);
    chk("flush_nowe", 64'(early_we), 64'd0);
    chk("flush_hold", {hi_o, lo_o}, {32'd2, 32'd14});

    // flush in FIN suppresses the write
    launch(1, 2'b01, 32'd6, 32'd7, 0, 2'b00, 0, 0);
    advance(33);
    flush_i = 1'b1;
    #1;
    chk("finflush", {hilo_we_o, stall_o, hi_o, lo_o},
        {2'b00, 32'd2, 32'd14});
    tick();
    flush_i = 1'b0;
    #1;
    chk("finflush_after", {busy_o, hi_o, lo_o}, {1'b0, 32'd2, 32'd14});

    // flush together with a new request in IDLE
    s0_valid_i = 1'b1; s0_op_i = 2'b01; s0_rs_i = 32'd9; s0_rt_i = 32'd9;
    flush_i = 1'b1;
    #1;
    chk("idleflush_stall", {63'd0, stall_o}, 64'd0);
    tick();
    s0_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("idleflush_busy", {63'd0, busy_o}, 64'd0);
    tick();

    // reset asserted during FIN
    launch(1, 2'b00, 32'd2, 32'd3, 0, 2'b00, 0, 0);
    advance(33);
    strobe("prerst", 32'd0, 32'd6);
    resetn = 1'b0;
    #1;
    chk("rst_fin", {busy_o, stall_o, hilo_we_o, hi_o, lo_o}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    launch(1, 2'b01, 32'd6, 32'd7, 0, 2'b00, 0, 0);
    advance(33);
    strobe("resume", 32'd0, 32'd42);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
